// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared LDPC block geometry, soft-value type and storage-bank states
package ldpc_pkg;
  localparam int LDPC_ROWS = 6;
  localparam int LDPC_COLS = 7;
  localparam int LDPC_LLR_W = 8;
  typedef logic [LDPC_LLR_W-1:0] llr_t;
  typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL} bank_st_t;
endpackage

// File: rtl/ldpc_r2c_bank.sv
// ldpc_r2c_bank: one 6x7 soft-value register bank, written a row at a time, read a column at a time
module ldpc_r2c_bank
  import ldpc_pkg::*;
(
  input  logic                  clk,
  input  logic                  we,
  input  logic [2:0]            row,
  input  llr_t [LDPC_COLS-1:0]  wdata,
  input  logic [2:0]            col,
  output llr_t [LDPC_ROWS-1:0]  rdata
);
  llr_t [LDPC_COLS-1:0] mem [LDPC_ROWS];
  always_ff @(posedge clk)
    if (we) mem[row] <= wdata;
  always_comb
    for (int r = 0; r < LDPC_ROWS; r++) rdata[r] = mem[r][col];
endmodule

// File: rtl/ldpc_row_to_column.sv
// ldpc_row_to_column: ping-pong transpose of 6x7 LDPC soft-value blocks, rows in, columns out.
// Defining LDPC_ROW_TO_COLUMN_LAST_EN adds the o_last end-of-block marker.
module ldpc_row_to_column
  import ldpc_pkg::*;
(
  input  logic i_clock,
  input  logic i_reset,
  input  llr_t i_data_0,
  input  llr_t i_data_1,
  input  llr_t i_data_2,
  input  llr_t i_data_3,
  input  llr_t i_data_4,
  input  llr_t i_data_5,
  input  llr_t i_data_6,
  input  logic i_valid,
  output logic o_ready,
  output llr_t o_data_0,
  output llr_t o_data_1,
  output llr_t o_data_2,
  output llr_t o_data_3,
  output llr_t o_data_4,
  output llr_t o_data_5,
  output logic o_valid
`ifdef LDPC_ROW_TO_COLUMN_LAST_EN
  ,
  output logic o_last
`endif
);
  bank_st_t st [2];
  logic wr_ptr, rd_ptr;
  logic [2:0] wr_row, rd_col;
  llr_t [LDPC_COLS-1:0] row_in;
  llr_t [LDPC_ROWS-1:0] col_out [2];
  llr_t [LDPC_ROWS-1:0] col_q;
  logic accept, fill_done, bypass, emit, rd_done;
  assign row_in = {i_data_6, i_data_5, i_data_4, i_data_3, i_data_2, i_data_1, i_data_0};
  assign o_ready = st[wr_ptr] != BANK_FULL;
  assign accept = i_valid && o_ready;
  assign fill_done = accept && wr_row == 3'(LDPC_ROWS - 1);
  // A block completing into an idle read side emits column 0 at once, last row taken from the input
  assign bypass = fill_done && wr_ptr == rd_ptr;
  assign emit = st[rd_ptr] == BANK_FULL || bypass;
  assign rd_done = emit && rd_col == 3'(LDPC_COLS - 1);
  for (genvar b = 0; b < 2; b++) begin : g_bank
    ldpc_r2c_bank u_bank (
      .clk(i_clock),
      .we(accept && wr_ptr == 1'(b)),
      .row(wr_row),
      .wdata(row_in),
      .col(rd_col),
      .rdata(col_out[b])
    );
  end
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      st <= '{BANK_EMPTY, BANK_EMPTY};
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      wr_row <= '0;
      rd_col <= '0;
      o_valid <= 1'b0;
      col_q <= '0;
    end else begin
      if (accept) begin
        st[wr_ptr] <= fill_done ? BANK_FULL : BANK_FILLING;
        wr_row <= fill_done ? '0 : wr_row + 3'd1;
        wr_ptr <= wr_ptr ^ fill_done;
      end
      if (rd_done) st[rd_ptr] <= BANK_EMPTY;
      if (emit) begin
        rd_col <= rd_done ? '0 : rd_col + 3'd1;
        rd_ptr <= rd_ptr ^ rd_done;
        col_q <= col_out[rd_ptr];
        if (bypass) col_q[LDPC_ROWS-1] <= i_data_0;
      end
      o_valid <= emit;
    end
  assign o_data_0 = col_q[0];
  assign o_data_1 = col_q[1];
  assign o_data_2 = col_q[2];
  assign o_data_3 = col_q[3];
  assign o_data_4 = col_q[4];
  assign o_data_5 = col_q[5];
`ifdef LDPC_ROW_TO_COLUMN_LAST_EN
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) o_last <= 1'b0;
    else o_last <= rd_done;
`endif
endmodule

// File: tb/tb_ldpc_row_to_column.sv
// tb_ldpc_row_to_column: randomized bench with a block-level schedule model for the row-to-column transpose
module tb_ldpc_row_to_column;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_valid = 1'b0;
  logic [55:0] din = '0;
  logic o_ready, o_valid;
  logic [7:0] o_data_0, o_data_1, o_data_2, o_data_3, o_data_4, o_data_5;
  logic [47:0] dout;
`ifdef LDPC_ROW_TO_COLUMN_LAST_EN
  logic o_last;
`endif
  int total = 0;
  int bad = 0;
  int n = 0;
  typedef struct { int t; logic [47:0] d; bit last; } beat_t;
  beat_t q[$];
  int ends[$];
  logic [55:0] rows_buf [6];
  int rows = 0;
  int next_free = 0;
  int start;
  logic [47:0] hold = '0;
  beat_t nb;
  bit exp_v, exp_l;

  always #5 clk = ~clk;

  ldpc_row_to_column dut (
    .i_clock(clk), .i_reset(rst),
    .i_data_0(din[7:0]), .i_data_1(din[15:8]), .i_data_2(din[23:16]), .i_data_3(din[31:24]),
    .i_data_4(din[39:32]), .i_data_5(din[47:40]), .i_data_6(din[55:48]),
    .i_valid(i_valid), .o_ready(o_ready),
    .o_data_0(o_data_0), .o_data_1(o_data_1), .o_data_2(o_data_2),
    .o_data_3(o_data_3), .o_data_4(o_data_4), .o_data_5(o_data_5),
    .o_valid(o_valid)
`ifdef LDPC_ROW_TO_COLUMN_LAST_EN
    , .o_last(o_last)
`endif
  );
  assign dout = {o_data_5, o_data_4, o_data_3, o_data_2, o_data_1, o_data_0};

  // Reference: each completed block is scheduled as 7 column beats starting at the completing
  // edge, or right after the previous block's last beat; a block holds storage until its last beat.
  initial forever begin
    @(negedge clk);
    n++;
    if (rst) begin
      q.delete(); ends.delete(); rows = 0; next_free = 0; hold = '0;
    end else if (i_valid && ends.size() < 2) begin
      rows_buf[rows] = din;
      rows++;
      if (rows == 6) begin
        start = n > next_free ? n : next_free;
        for (int c = 0; c < 7; c++) begin
          nb.t = start + c;
          nb.last = (c == 6);
          for (int r = 0; r < 6; r++) nb.d[8*r +: 8] = rows_buf[r][8*c +: 8];
          q.push_back(nb);
        end
        ends.push_back(start + 6);
        next_free = start + 7;
        rows = 0;
      end
    end
    while (ends.size() > 0 && ends[0] <= n) void'(ends.pop_front());
    exp_v = q.size() > 0 && q[0].t == n;
    exp_l = exp_v && q[0].last;
    if (exp_v) begin hold = q[0].d; void'(q.pop_front()); end
    total++;
    if (o_valid !== exp_v) begin bad++; $display("FAIL mon_valid edge=%0d got=%b want=%b", n, o_valid, exp_v); end
    total++;
    if (dout !== hold) begin bad++; $display("FAIL mon_data edge=%0d got=%h want=%h", n, dout, hold); end
    total++;
    if (o_ready !== (ends.size() < 2)) begin bad++; $display("FAIL mon_ready edge=%0d got=%b want=%b", n, o_ready, ends.size() < 2); end
`ifdef LDPC_ROW_TO_COLUMN_LAST_EN
    total++;
    if (o_last !== exp_l) begin bad++; $display("FAIL mon_last edge=%0d got=%b want=%b", n, o_last, exp_l); end
`endif
  end

  function automatic logic [55:0] pat_row(input int r);
    logic [55:0] x;
    for (int c = 0; c < 7; c++) x[8*c +: 8] = {4'(r), 4'(c)};
    return x;
  endfunction

  function automatic logic [47:0] pat_col(input int c);
    logic [47:0] x;
    for (int r = 0; r < 6; r++) x[8*r +: 8] = {4'(r), 4'(c)};
    return x;
  endfunction

  function automatic logic [55:0] rnd_row();
    logic [55:0] x;
    for (int c = 0; c < 7; c++) x[8*c +: 8] = 8'($urandom_range(254, 0));
    return x;
  endfunction

  task automatic step(input logic v, input logic [55:0] d);
    @(negedge clk); #1;
    i_valid = v;
    din = d;
  endtask

  task automatic wait_idle();
    int k = 0;
    i_valid = 1'b0;
    while ((q.size() != 0 || o_valid) && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    total++;
    if (k >= 100) begin bad++; $display("FAIL idle_timeout got=%0d want<100 cycles", k); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    @(negedge clk); @(negedge clk);
    total++;
    if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_valid); end
    total++;
    if (dout !== 48'h0) begin bad++; $display("FAIL reset_data got=%h want=0", dout); end
`ifdef LDPC_ROW_TO_COLUMN_LAST_EN
    total++;
    if (o_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", o_last); end
`endif
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", o_ready); end
  endtask

  task automatic test_single_block();
    for (int r = 0; r < 6; r++) step(1'b1, pat_row(r));
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      total++;
      if (o_valid !== 1'b1 || dout !== pat_col(c))
        begin bad++; $display("FAIL single_beat%0d got v=%b d=%h want v=1 d=%h", c, o_valid, dout, pat_col(c)); end
`ifdef LDPC_ROW_TO_COLUMN_LAST_EN
      total++;
      if (o_last !== (c == 6)) begin bad++; $display("FAIL single_last%0d got=%b want=%b", c, o_last, c == 6); end
`endif
      #1 i_valid = 1'b0;
    end
    @(negedge clk);
    total++;
    if (o_valid !== 1'b0) begin bad++; $display("FAIL single_tail got=%b want=0", o_valid); end
  endtask

  task automatic test_toggle();
    int run = 0;
    int runs = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (o_valid) run++;
      else if (run > 0) begin
        total++;
        if (run !== 7) begin bad++; $display("FAIL toggle_run got=%0d want=7", run); end
        runs++;
        run = 0;
      end
      #1;
      i_valid = (i < 24) && (i % 2 == 0);
      din = rnd_row();
    end
    total++;
    if (runs !== 2) begin bad++; $display("FAIL toggle_blocks got=%0d want=2", runs); end
  endtask

  task automatic test_continuous();
    int beats = 0;
    int first = -1;
    int last = -1;
    int nr = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (o_valid) begin
        beats++;
        if (first < 0) first = i;
        last = i;
      end
      #1;
      i_valid = (i < 26);
      din = rnd_row();
      if (i_valid && !o_ready) nr++;
    end
    total++;
    if (beats !== 28) begin bad++; $display("FAIL cont_beats got=%0d want=28", beats); end
    total++;
    if (first !== 6) begin bad++; $display("FAIL cont_first got=%0d want=6", first); end
    total++;
    if (last !== 33) begin bad++; $display("FAIL cont_last got=%0d want=33", last); end
    total++;
    if (nr !== 2) begin bad++; $display("FAIL cont_stalls got=%0d want=2", nr); end
  endtask

  task automatic test_backpressure();
    int ff = 0;
    int held = 0;
    int acc = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      for (int r = 0; r < 6; r++) if (dout[8*r +: 8] == 8'hFF) ff++;
      #1;
      if (i < 50 || acc % 6 != 0) begin
        i_valid = 1'b1;
        if (o_ready) begin din = rnd_row(); acc++; end
        else begin din = '1; held++; end
      end else i_valid = 1'b0;
    end
    total++;
    if (ff !== 0) begin bad++; $display("FAIL bp_ff_seen got=%0d want=0", ff); end
    total++;
    if (held == 0) begin bad++; $display("FAIL bp_stall got=%0d want>0", held); end
  endtask

  task automatic test_mid_reset();
    int vc = 0;
    int seen = 0;
    for (int r = 0; r < 3; r++) step(1'b1, pat_row(r));
    @(negedge clk); #1;
    i_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_valid) vc++;
    end
    total++;
    if (vc !== 0) begin bad++; $display("FAIL mreset_valid got=%0d want=0", vc); end
    for (int r = 0; r < 6; r++) step(1'b1, pat_row(r));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_valid) begin
        total++;
        if (dout !== pat_col(seen)) begin bad++; $display("FAIL mreset_beat%0d got=%h want=%h", seen, dout, pat_col(seen)); end
        seen++;
      end
      #1 i_valid = 1'b0;
    end
    total++;
    if (seen !== 7) begin bad++; $display("FAIL mreset_count got=%0d want=7", seen); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_block();
    wait_idle();
    test_toggle();
    wait_idle();
    test_continuous();
    wait_idle();
    test_backpressure();
    wait_idle();
    test_mid_reset();
    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ldpc_row_to_column.md
LDPC_ROW_TO_COLUMN -- requirements
Module: ldpc_row_to_column

Interface
REQ-001 SHALL have no parameters; block geometry is fixed at 6 rows x 7 columns of 8-bit soft values.
REQ-002 i_clock  input  1  sole clock; all logic on rising edge.
REQ-003 i_reset  input  1  asynchronous, active-high reset.
REQ-004 i_data_0..i_data_6  input  8 each  one row beat; i_data_c is column c of the current row.
REQ-005 i_valid  input  1  row beat present.
REQ-006 o_ready  output  1  block can accept a row beat this cycle.
REQ-007 o_data_0..o_data_5  output  8 each  one column beat; o_data_r is row r of the current column.
REQ-008 o_valid  output  1  column beat present; downstream cannot stall.
REQ-009 o_last  output  1  final column (c=6) of a block; present only with LDPC_ROW_TO_COLUMN_LAST_EN.

Function
REQ-010 SHALL contain two 6x7-byte storage banks (ping-pong), each flagged empty, filling or full.
REQ-011 Row beat accepted when i_valid && o_ready; accepted beat written into write bank at row index wr_row (0..5).
REQ-012 i_valid while o_ready=0: beat SHALL be ignored; no storage write, no counter change.
REQ-013 wr_row increments per accepted beat; on accepting row 5, bank becomes full, wr_row wraps to 0, write-bank pointer toggles.
REQ-014 o_ready SHALL be 1 exactly when the current write bank is not full (registered flags, no combinational path from i_valid).
REQ-015 Read side: when the read bank is full, emit columns 0..6 on 7 consecutive cycles with o_valid=1; rd_col counts 0..6.
REQ-016 Column beat c: o_data_r = i_data_c of accepted row r of that block, r=0..5.
REQ-017 Latency: column 0 SHALL appear with o_valid=1 on the cycle after the edge that accepted row 5 (if read side idle).
REQ-018 After column 6, read bank becomes empty at that clock edge, read pointer toggles; o_ready for that bank rises the following cycle.
REQ-019 If the other bank is full when a read completes, its column 0 SHALL follow with no idle cycle.
REQ-020 Simultaneous fill-complete of one bank and read-complete of the other in one cycle SHALL both take effect; no block lost or duplicated.
REQ-021 o_data_* and o_valid SHALL be registered; o_data_* hold last value when o_valid=0.
REQ-022 Blocks SHALL emerge strictly in acceptance order.

Reset
REQ-023 On i_reset: o_valid=0, o_data_*=0, o_last=0, wr_row=0, rd_col=0, both banks empty, both pointers to bank 0, o_ready=1 on the cycle after reset deasserts.
REQ-024 Reset mid-block SHALL discard partial and full banks; bank storage contents are not reset.

Configuration
REQ-025 Macro LDPC_ROW_TO_COLUMN_LAST_EN: defined -> o_last port exists, asserted with o_valid on column 6 only, reset 0; undefined -> port and logic absent, all other behaviour identical.

Structure
REQ-026 Shared package ldpc_pkg SHALL hold LDPC_ROWS=6, LDPC_COLS=7, LDPC_LLR_W=8 and typedef llr_t (logic [7:0]); shared with ldpc_column_to_row.
REQ-027 One sub-module ldpc_r2c_bank (single 6x7 register bank: row write, column read) SHALL be instantiated twice; control stays in top.

Verification
REQ-028 One block, row r data i_data_c = {r[3:0],c[3:0]}, i_valid 6 cycles -> 7 beats, beat c o_data_r = {r,c}, first beat 1 cycle after last row.
REQ-029 Continuous i_valid=1 for 4 blocks -> 28 column beats, in order, no loss; o_ready low while both banks full, total throughput 6 rows per 7 cycles.
REQ-030 i_valid toggling 1/0 -> output identical to REQ-028 per block; o_valid gaps only between blocks.
REQ-031 i_valid=1 with o_ready=0, data 8'hFF -> 8'hFF never appears on o_data_*.
REQ-032 i_reset pulsed after 3 rows of block 0 -> no o_valid; next 6 rows produce a correct block.
REQ-033 With LDPC_ROW_TO_COLUMN_LAST_EN: o_last=1 only on beat 6 of each block; without: port absent, REQ-028 passes unchanged.
